// File: rtl/serial_adder_ctrl.sv
// Bit-serial LSB-first adder: one full_adder cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= {fa_s, res[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_c;
                    if (!last) cnt <= cnt + CW'(1);
                    // Publish straight from the adder so the result is valid in DONE
                    if (last) begin
                        sum  <= {fa_s, res[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB is the held carry while the last bit is added
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf <= 1'b0;
        else if (state == RUN && last) ovf <= carry ^ fa_c;
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 vectors plus WIDTH=2 sweep.
// Overflow vectors run only when SERIAL_ADD_OVF_EN is defined.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
    logic       ovf2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf2),
`endif
        .cout  (cout2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge; lat = edges from accepting edge to done
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, output int lat);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb,
                           input logic tc, output int lat);
        @(posedge clk); #1;
        a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic end_pulse();
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int gap;
        logic [2:0] exp2;

        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, lat);
        chk("t1_lat", lat, 8);
        chk("t1_sum", sum, 8'h10);
        chk("t1_cout", cout, 1'b0);
        end_pulse();
        chk("t1_hold_sum", sum, 8'h10);

        run_op(8'hFF, 8'h01, 1'b0, lat);
        chk("t2a_lat", lat, 8);
        chk("t2a_sum", sum, 8'h00);
        chk("t2a_cout", cout, 1'b1);
        end_pulse();
        run_op(8'hFF, 8'hFF, 1'b1, lat);
        chk("t2b_sum", sum, 8'hFF);
        chk("t2b_cout", cout, 1'b1);
        end_pulse();

        // start held high; operand change after capture must not matter
        @(posedge clk); #1;
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hAA;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t3_lat", lat, 8);
        chk("t3_sum", sum, 8'h07);
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!done && gap < 40);
        chk("t3_gap", gap, 10);
        chk("t3_sum2", sum, 8'hAE);
        start = 1'b0;
        end_pulse();

        // Asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_done", done, 1'b0);
        chk("t4_sum", sum, 8'h00);
        chk("t4_cout", cout, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gap = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) gap++;
        end
        chk("t4_no_done", gap, 0);
        run_op(8'h55, 8'hAA, 1'b1, lat);
        chk("t4_lat", lat, 8);
        chk("t4_sum_after", sum, 8'h00);
        chk("t4_cout_after", cout, 1'b1);
        end_pulse();

`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, lat);
        chk("t5a_sum", sum, 8'h80);
        chk("t5a_ovf", ovf, 1'b1);
        chk("t5a_cout", cout, 1'b0);
        end_pulse();
        run_op(8'h80, 8'h80, 1'b0, lat);
        chk("t5b_sum", sum, 8'h00);
        chk("t5b_ovf", ovf, 1'b1);
        chk("t5b_cout", cout, 1'b1);
        end_pulse();
        run_op(8'h10, 8'h20, 1'b0, lat);
        chk("t5c_sum", sum, 8'h30);
        chk("t5c_ovf", ovf, 1'b0);
        end_pulse();
`endif

        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            exp2 = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
            run_op2(v[4:3], v[2:1], v[0], lat);
            chk("t6_lat", lat, 2);
            chk("t6_res", {cout2, sum2}, exp2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
